ras_ctrl: RTL
=============

Name: ras_ctrl

Overview:
- Front-end control stage directly upstream of the return address stack (RAS).
- Accepts per-instruction call/return classification from the fetch/scan logic through a valid/ready handshake.
- Computes the return address and drives the RAS push/pop/data inputs from a registered stage.
- Tracks RAS occupancy so underflowing pops are suppressed, and returns the RAS top-of-stack as a registered return-target prediction.

Parameters:
- VLEN, 64: virtual address width; width of PC, return address and prediction target.
- DEPTH, 2: RAS depth; must match the RAS instance; occupancy saturates at this value.
- BLANK_CYCLES, 2: cycles ready_o is held low after a flush; 0 disables blanking.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_bp_i  in  1  branch-prediction flush; the same signal drives the RAS flush.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept.
- pc_i  in  VLEN  PC of the instruction.
- is_call_i  in  1  instruction is a call (push).
- is_ret_i  in  1  instruction is a return (pop).
- is_rvc_i  in  1  instruction is 16-bit compressed.
- ras_valid_i  in  1  RAS top-of-stack valid bit.
- ras_ra_i  in  VLEN  RAS top-of-stack address.
- push_o  out  1  RAS push.
- pop_o  out  1  RAS pop.
- data_o  out  VLEN  address to push.
- pred_valid_o  out  1  return prediction valid.
- pred_target_o  out  VLEN  predicted return target.
- occupancy_o  out  $clog2(DEPTH+1)  tracked valid RAS entries.

Behaviour:
- Reset (rst_i high, async): state=RUN; push_o, pop_o, pred_valid_o = 0; data_o, pred_target_o, occupancy_o = 0; blank counter = 0. While rst_i is high, no input is accepted.
- ready_o = (state==RUN). Accept = valid_i & ready_o & !flush_bp_i. Non-accepted inputs have no effect.
- Latency: 1 cycle. Outputs are registered. The cycle after an accept, push_o/pop_o/pred_valid_o reflect that instruction for exactly one cycle. With no accept, they are 0 the next cycle. data_o and pred_target_o hold their last value.
- Return address: data_o = pc_i + (is_rvc_i ? 2 : 4), modulo 2^VLEN (wraps, no carry out).
- pop_eff = is_ret_i & (occupancy_o != 0). push_eff = is_call_i.
- On accept:
  - push_o <= push_eff; pop_o <= pop_eff.
  - pred_valid_o <= pop_eff & ras_valid_i; pred_target_o <= ras_ra_i, sampled in the accept cycle.
- Occupancy update on accept:
  - push only: min(occ+1, DEPTH). Saturation models the RAS dropping its bottom entry.
  - pop only: occ-1.
  - push & pop (co-routine call/return): occ unchanged. The RAS replaces its top entry. The prediction is still the old top.
  - Return with occ==0: pop suppressed, pred_valid_o=0. If it is also a call, it is treated as push only (occ becomes 1).
  - Neither call nor return: no change, no RAS activity.
- Flush (flush_bp_i high):
  - Next cycle: push_o, pop_o, pred_valid_o = 0 and occupancy_o = 0.
  - Any instruction presented in the flush cycle is dropped.
  - An operation already registered and driven in the flush cycle is overridden by the RAS's own flush. The block does not re-issue it.
- FSM:
  - RUN --flush_bp_i & BLANK_CYCLES>0--> BLANK, counter loaded with BLANK_CYCLES-1.
  - BLANK: ready_o=0; counter decrements; at counter==0 --> RUN.
  - flush_bp_i in BLANK reloads the counter.
  - With BLANK_CYCLES==0, the block stays in RUN; the flush only clears outputs and occupancy.
- Reset asserted mid-operation: immediate return to reset values. In-flight operations are lost.

Optional Feature:
- Macro RAS_CTRL_STATS_EN.
- When defined, adds two outputs:
  - underflow_cnt_o [31:0]: increments on each accepted return with occ==0.
  - overflow_cnt_o [31:0]: increments on each accepted push-only with occ==DEPTH.
- Both counters saturate at 32'hFFFF_FFFF, are cleared only by rst_i, and are unaffected by flush_bp_i.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Call with pc_i=0x1000, is_rvc_i=0, accepted at cycle N -> cycle N+1: push_o=1, data_o=0x1004, occupancy_o=1; cycle N+2: push_o=0.
- Return with occ=1, ras_valid_i=1, ras_ra_i=0x1004 -> next cycle: pop_o=1, pred_valid_o=1, pred_target_o=0x1004, occupancy_o=0.
- Return with occ=0 -> pop_o=0, pred_valid_o=0, occupancy_o stays 0; with the macro defined, underflow_cnt_o=1.
- DEPTH=2, three calls with pc_i=0xFFFF_FFFF_FFFF_FFFE and is_rvc_i=1 -> data_o=0x0 (wrap), occupancy_o saturates at 2; with the macro defined, overflow_cnt_o=1.
- Call+return same instruction at occ=2, ras_ra_i=0x2000 -> push_o=1, pop_o=1, pred_target_o=0x2000, occupancy_o=2.
- flush_bp_i pulse concurrent with valid_i and BLANK_CYCLES=2 -> input dropped, outputs 0, occupancy_o=0, ready_o low for exactly 2 cycles then high.

Source files
------------

// File: rtl/ras_ctrl.sv
// Control stage in front of the return address stack: computes push/pop/data, tracks occupancy
// and registers the return-target prediction. Define RAS_CTRL_STATS_EN for under/overflow counters.
module ras_ctrl #(
    parameter int unsigned VLEN         = 64,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_bp_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [VLEN-1:0]                  pc_i,
    input  logic                             is_call_i,
    input  logic                             is_ret_i,
    input  logic                             is_rvc_i,
    input  logic                             ras_valid_i,
    input  logic [VLEN-1:0]                  ras_ra_i,
    output logic                             push_o,
    output logic                             pop_o,
    output logic [VLEN-1:0]                  data_o,
    output logic                             pred_valid_o,
    output logic [VLEN-1:0]                  pred_target_o,
`ifdef RAS_CTRL_STATS_EN
    output logic [31:0]                      underflow_cnt_o,
    output logic [31:0]                      overflow_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0]       occupancy_o
);

    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    typedef enum logic {StRun, StBlank} state_e;

    state_e          r_state;
    logic [CW-1:0]   r_blank_cnt;
    logic            r_push;
    logic            r_pop;
    logic            r_pred_valid;
    logic [VLEN-1:0] r_data;
    logic [VLEN-1:0] r_pred_target;
    logic [OW-1:0]   r_occ;

    logic            w_accept;
    logic            w_occ_empty;
    logic            w_occ_full;
    logic            w_pop_eff;
    logic [VLEN-1:0] w_ret_addr;
    logic [OW-1:0]   w_occ_next;

    always_comb begin
        w_accept    = valid_i & (r_state == StRun) & ~flush_bp_i;
        w_occ_empty = (r_occ == '0);
        w_occ_full  = (r_occ == OW'(DEPTH));
        w_pop_eff   = is_ret_i & ~w_occ_empty;
        w_ret_addr  = pc_i + (is_rvc_i ? VLEN'(2) : VLEN'(4));
        // Call+return replaces the top entry, so occupancy is unchanged.
        w_occ_next  = r_occ;
        if (is_call_i && !w_pop_eff) begin
            w_occ_next = w_occ_full ? r_occ : r_occ + OW'(1);
        end else if (!is_call_i && w_pop_eff) begin
            w_occ_next = r_occ - OW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= StRun;
            r_blank_cnt   <= '0;
            r_push        <= 1'b0;
            r_pop         <= 1'b0;
            r_pred_valid  <= 1'b0;
            r_data        <= '0;
            r_pred_target <= '0;
            r_occ         <= '0;
        end else begin
            r_push       <= 1'b0;
            r_pop        <= 1'b0;
            r_pred_valid <= 1'b0;
            if (flush_bp_i) begin
                r_occ <= '0;
                if (BLANK_CYCLES > 0) begin
                    r_state     <= StBlank;
                    r_blank_cnt <= CW'(BLANK_CYCLES - 1);
                end
            end else begin
                if (w_accept) begin
                    r_push        <= is_call_i;
                    r_pop         <= w_pop_eff;
                    r_pred_valid  <= w_pop_eff & ras_valid_i;
                    r_data        <= w_ret_addr;
                    r_pred_target <= ras_ra_i;
                    r_occ         <= w_occ_next;
                end
                if (r_state == StBlank) begin
                    if (r_blank_cnt == '0) begin
                        r_state <= StRun;
                    end else begin
                        r_blank_cnt <= r_blank_cnt - CW'(1);
                    end
                end
            end
        end
    end

`ifdef RAS_CTRL_STATS_EN
    logic [31:0] r_underflow_cnt;
    logic [31:0] r_overflow_cnt;

    // Flush does not touch the statistics; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_underflow_cnt <= '0;
            r_overflow_cnt  <= '0;
        end else begin
            if (w_accept && is_ret_i && w_occ_empty && r_underflow_cnt != '1) begin
                r_underflow_cnt <= r_underflow_cnt + 32'd1;
            end
            if (w_accept && is_call_i && !w_pop_eff && w_occ_full && r_overflow_cnt != '1) begin
                r_overflow_cnt <= r_overflow_cnt + 32'd1;
            end
        end
    end

    assign underflow_cnt_o = r_underflow_cnt;
    assign overflow_cnt_o  = r_overflow_cnt;
`endif

    assign ready_o       = (r_state == StRun);
    assign push_o        = r_push;
    assign pop_o         = r_pop;
    assign pred_valid_o  = r_pred_valid;
    assign data_o        = r_data;
    assign pred_target_o = r_pred_target;
    assign occupancy_o   = r_occ;

endmodule
